// File: rtl/cpu_control_pkg.sv
// Shared definitions for the 8-bit CPU sequencer: instruction classes, FSM states,
// flag bit positions and the ALU operation codes the sequencer passes through.
package cpu_control_pkg;

  localparam logic [2:0] CLS_ALU  = 3'b000;
  localparam logic [2:0] CLS_ALUI = 3'b001;
  localparam logic [2:0] CLS_LDB  = 3'b010;
  localparam logic [2:0] CLS_JMP  = 3'b011;
  localparam logic [2:0] CLS_BR   = 3'b100;
  localparam logic [2:0] CLS_HALT = 3'b101;

  // flags_o is packed {N,V,C,Z}
  localparam int FLG_Z = 0;
  localparam int FLG_C = 1;
  localparam int FLG_V = 2;
  localparam int FLG_N = 3;

  localparam logic [4:0] OP_ADD    = 5'h00;
  localparam logic [4:0] OP_SUB    = 5'h01;
  localparam logic [4:0] OP_AND    = 5'h02;
  localparam logic [4:0] OP_OR     = 5'h03;
  localparam logic [4:0] OP_XOR    = 5'h04;
  localparam logic [4:0] OP_PASS_B = 5'h05;

  typedef enum logic [2:0] {
    S_RESET     = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_FETCH_IMM = 3'd3,
    S_EXEC      = 3'd4,
    S_HALT      = 3'd5,
    S_ERROR     = 3'd6
  } state_t;

  function automatic logic cls_has_imm(input logic [2:0] cls);
    return (cls == CLS_ALUI) || (cls == CLS_LDB) || (cls == CLS_JMP) || (cls == CLS_BR);
  endfunction

endpackage

// File: rtl/cpu_control_branch_eval.sv
// Branch condition: cond[1:0] picks Z/C/V/N, cond[2] is the flag polarity that means taken.
module cpu_control_branch_eval
  import cpu_control_pkg::*;
(
  input  logic [3:0] flags,
  input  logic [2:0] cond,
  output logic       taken
);

  logic sel;

  always_comb begin
    sel = flags[FLG_Z];
    case (cond[1:0])
      2'd1:    sel = flags[FLG_C];
      2'd2:    sel = flags[FLG_V];
      2'd3:    sel = flags[FLG_N];
      default: sel = flags[FLG_Z];
    endcase
    taken = (sel == cond[2]);
  end

endmodule

// File: rtl/cpu_control.sv
// Multi-cycle fetch/decode/execute sequencer for the 8-bit CPU.
// state       | meaning
// S_RESET     | one idle cycle after reset release
// S_FETCH     | request opcode byte at PC
// S_DECODE    | classify IR
// S_FETCH_IMM | request immediate byte at PC
// S_EXEC      | apply class action, back to fetch
// S_HALT      | HALT executed, terminal
// S_ERROR     | illegal opcode, terminal
module cpu_control
  import cpu_control_pkg::*;
#(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic       clk_i,
  input  logic       rst_i,
  output logic       mem_req_o,
  output logic [7:0] mem_addr_o,
  input  logic [7:0] mem_rdata_i,
  input  logic       mem_valid_i,
  output logic [7:0] alu_a_o,
  output logic [7:0] alu_b_o,
  output logic [4:0] alu_op_o,
  input  logic [7:0] alu_y_i,
  input  logic       alu_z_i,
  input  logic       alu_c_i,
  input  logic       alu_v_i,
  input  logic       alu_n_i,
  output logic [7:0] pc_o,
  output logic [7:0] a_o,
  output logic [3:0] flags_o,
  output logic       halted_o,
  output logic       error_o
);

  state_t     state, state_nxt;
  logic [7:0] pc, a, b, ir, imm;
  logic [3:0] flags;
  logic [2:0] cls;
  logic       br_taken;

  assign cls = ir[7:5];

  cpu_control_branch_eval u_branch (
    .flags (flags),
    .cond  (ir[2:0]),
    .taken (br_taken)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= S_RESET;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    mem_req_o = 1'b0;
    case (state)
      S_RESET: state_nxt = S_FETCH;
      S_FETCH: begin
        mem_req_o = 1'b1;
        if (mem_valid_i) state_nxt = S_DECODE;
      end
      S_DECODE: begin
        if (cls == CLS_ALU)          state_nxt = S_EXEC;
        else if (cls_has_imm(cls))   state_nxt = S_FETCH_IMM;
        else if (cls == CLS_HALT)    state_nxt = S_HALT;
        else                         state_nxt = S_ERROR;
      end
      S_FETCH_IMM: begin
        mem_req_o = 1'b1;
        if (mem_valid_i) state_nxt = S_EXEC;
      end
      S_EXEC:  state_nxt = S_FETCH;
      S_HALT:  state_nxt = S_HALT;
      S_ERROR: state_nxt = S_ERROR;
      default: state_nxt = S_ERROR;
    endcase
  end

  // PC already points past the immediate when EXEC runs, so a not-taken branch needs no update.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc    <= RESET_PC;
      a     <= 8'h00;
      b     <= 8'h00;
      ir    <= 8'h00;
      imm   <= 8'h00;
      flags <= 4'h0;
    end else begin
      case (state)
        S_FETCH: begin
          if (mem_valid_i) begin
            ir <= mem_rdata_i;
            pc <= pc + 8'd1;
          end
        end
        S_FETCH_IMM: begin
          if (mem_valid_i) begin
            imm <= mem_rdata_i;
            pc  <= pc + 8'd1;
          end
        end
        S_EXEC: begin
          case (cls)
            CLS_ALU, CLS_ALUI: begin
              a     <= alu_y_i;
              flags <= {alu_n_i, alu_v_i, alu_c_i, alu_z_i};
            end
            CLS_LDB: b  <= imm;
            CLS_JMP: pc <= imm;
            CLS_BR:  if (br_taken) pc <= imm;
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  assign mem_addr_o = pc;
  assign alu_a_o    = a;
  assign alu_b_o    = (cls == CLS_ALUI) ? imm : b;
  assign alu_op_o   = ir[4:0];
  assign pc_o       = pc;
  assign a_o        = a;
  assign flags_o    = flags;
  assign halted_o   = (state == S_HALT);
  assign error_o    = (state == S_ERROR);

endmodule

// File: tb/tb_cpu_control.sv
// Bench for cpu_control: instruction-level reference model plus a memory responder with wait states.
module tb_cpu_control;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       mem_req_o;
  logic [7:0] mem_addr_o;
  logic [7:0] mem_rdata_i = 8'h00;
  logic       mem_valid_i = 1'b0;
  logic [7:0] alu_a_o, alu_b_o;
  logic [4:0] alu_op_o;
  logic [7:0] alu_y_i;
  logic       alu_z_i, alu_c_i, alu_v_i, alu_n_i;
  logic [7:0] pc_o, a_o;
  logic [3:0] flags_o;
  logic       halted_o, error_o;

  always #5 clk_i = ~clk_i;

  cpu_control #(.RESET_PC(8'h00)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
    .mem_rdata_i(mem_rdata_i), .mem_valid_i(mem_valid_i),
    .alu_a_o(alu_a_o), .alu_b_o(alu_b_o), .alu_op_o(alu_op_o),
    .alu_y_i(alu_y_i), .alu_z_i(alu_z_i), .alu_c_i(alu_c_i),
    .alu_v_i(alu_v_i), .alu_n_i(alu_n_i),
    .pc_o(pc_o), .a_o(a_o), .flags_o(flags_o),
    .halted_o(halted_o), .error_o(error_o)
  );

  // ALU of the surrounding datapath; returns {N,V,C,Z,result}
  function automatic logic [11:0] alu_fn(input logic [4:0] op, input logic [7:0] x, input logic [7:0] y);
    logic [8:0] s;
    logic [7:0] r;
    logic       c, v;
    s = 9'h000; c = 1'b0; v = 1'b0;
    case (op)
      5'h00: begin s = {1'b0, x} + {1'b0, y}; r = s[7:0]; c = s[8]; v = (x[7] == y[7]) && (r[7] != x[7]); end
      5'h01: begin s = {1'b0, x} - {1'b0, y}; r = s[7:0]; c = s[8]; v = (x[7] != y[7]) && (r[7] != x[7]); end
      5'h02: r = x & y;
      5'h03: r = x | y;
      5'h04: r = x ^ y;
      5'h05: r = y;
      default: r = ~x;
    endcase
    return {r[7], v, c, (r == 8'h00), r};
  endfunction

  assign {alu_n_i, alu_v_i, alu_c_i, alu_z_i, alu_y_i} = alu_fn(alu_op_o, alu_a_o, alu_b_o);

  logic [7:0] mem [256];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // responder controls and reference-model state
  int  cyc = 0;
  int  wait_mode = 0;   // <0: random 0..3 wait cycles per fetch
  bit  force_valid = 1'b0;

  logic [7:0] m_pc, m_a, m_b, m_imm, m_ir;
  logic [3:0] m_flags;
  int  m_term;          // 0 running, 1 halt, 2 error
  int  term_cyc;
  bit  have_prev;
  int  last_acc, prev_lat, waits_acc;
  bit  in_fetch, was_waiting, exp_imm;
  int  wait_left;
  logic [7:0] exp_imm_addr, held_addr, held_pc;
  int  acc_cnt;
  logic [7:0] op_addr_q[$];
  int  op_cyc_q[$];

  task automatic model_reset();
    m_pc = 8'h00; m_a = 8'h00; m_b = 8'h00; m_imm = 8'h00; m_ir = 8'h00; m_flags = 4'h0;
    m_term = 0; term_cyc = 0; have_prev = 1'b0; last_acc = 0; prev_lat = 0; waits_acc = 0;
    in_fetch = 1'b0; was_waiting = 1'b0; exp_imm = 1'b0; wait_left = 0;
    acc_cnt = 0; op_addr_q.delete(); op_cyc_q.delete();
  endtask

  // Execute one whole instruction at opcode acceptance; later fetches are checked against it.
  task automatic model_step();
    logic [7:0]  op, imm;
    logic [2:0]  cls;
    logic [11:0] r;
    logic        f, z, c, v, n;
    op = mem[m_pc];
    m_ir = op;
    m_pc = m_pc + 8'd1;
    cls = op[7:5];
    imm = 8'h00;
    if (cls >= 3'd1 && cls <= 3'd4) begin
      imm = mem[m_pc];
      exp_imm = 1'b1;
      exp_imm_addr = m_pc;
      m_pc = m_pc + 8'd1;
      m_imm = imm;
      prev_lat = 4;
    end else begin
      prev_lat = 3;
    end
    {n, v, c, z} = m_flags;
    case (cls)
      3'd0: begin r = alu_fn(op[4:0], m_a, m_b); m_a = r[7:0]; m_flags = r[11:8]; end
      3'd1: begin r = alu_fn(op[4:0], m_a, imm); m_a = r[7:0]; m_flags = r[11:8]; end
      3'd2: m_b = imm;
      3'd3: m_pc = imm;
      3'd4: begin
        case (op[1:0])
          2'd0: f = z;
          2'd1: f = c;
          2'd2: f = v;
          default: f = n;
        endcase
        if (f == op[2]) m_pc = imm;
      end
      3'd5: begin m_term = 1; term_cyc = cyc + 2; end
      default: begin m_term = 2; term_cyc = cyc + 2; end
    endcase
  endtask

  task automatic accept_fetch();
    if (exp_imm) begin
      chk("imm_addr", mem_addr_o, exp_imm_addr);
      exp_imm = 1'b0;
    end else begin
      chk("op_addr", mem_addr_o, m_pc);
      chk("pc_at_fetch", pc_o, m_pc);
      chk("a_at_fetch", a_o, m_a);
      chk("alu_a", alu_a_o, m_a);
      chk("flags_at_fetch", flags_o, m_flags);
      chk("alu_b", alu_b_o, (m_ir[7:5] == 3'b001) ? m_imm : m_b);
      if (have_prev) chk("instr_gap", cyc - last_acc, prev_lat + waits_acc);
      op_addr_q.push_back(mem_addr_o);
      op_cyc_q.push_back(cyc);
      acc_cnt++;
      have_prev = 1'b1;
      last_acc = cyc;
      waits_acc = 0;
      model_step();
    end
  endtask

  always @(negedge clk_i) begin
    cyc++;
    if (rst_i) begin
      model_reset();
      mem_valid_i = force_valid;
      mem_rdata_i = 8'h5A;
    end else begin
      chk("halted", halted_o, (m_term == 1) && (cyc >= term_cyc));
      chk("error", error_o, (m_term == 2) && (cyc >= term_cyc));
      chk("alu_op", alu_op_o, m_ir[4:0]);
      if (m_term != 0 && cyc >= term_cyc - 1) chk("req_terminal", mem_req_o, 1'b0);
      if (m_term != 0 && cyc == term_cyc) begin
        chk("pc_terminal", pc_o, m_pc);
        chk("a_terminal", a_o, m_a);
        chk("flags_terminal", flags_o, m_flags);
      end
      if (mem_req_o) begin
        if (!in_fetch) begin
          in_fetch = 1'b1;
          was_waiting = 1'b0;
          wait_left = (wait_mode < 0) ? int'($urandom_range(0, 3)) : wait_mode;
        end else if (was_waiting) begin
          chk("addr_stable", mem_addr_o, held_addr);
          chk("pc_stable", pc_o, held_pc);
        end
        if (wait_left > 0) begin
          wait_left--;
          waits_acc++;
          was_waiting = 1'b1;
          held_addr = mem_addr_o;
          held_pc = pc_o;
          mem_valid_i = 1'b0;
          mem_rdata_i = 8'($urandom);
        end else begin
          mem_valid_i = 1'b1;
          mem_rdata_i = mem[mem_addr_o];
          in_fetch = 1'b0;
          was_waiting = 1'b0;
          accept_fetch();
        end
      end else begin
        if (in_fetch) begin
          chk("req_held", mem_req_o, 1'b1);
          in_fetch = 1'b0;
        end
        mem_valid_i = 1'($urandom_range(0, 1));
        mem_rdata_i = 8'($urandom);
      end
    end
  end

  function automatic logic [7:0] q_addr(input int i);
    if (op_addr_q.size() > i) return op_addr_q[i];
    return 8'hxx;
  endfunction

  function automatic int q_gap(input int i);
    if (op_cyc_q.size() > i + 1) return op_cyc_q[i+1] - op_cyc_q[i];
    return -1;
  endfunction

  task automatic do_reset();
    @(posedge clk_i); #2 rst_i = 1'b1;
    repeat (2) @(negedge clk_i);
    @(posedge clk_i); #1 rst_i = 1'b0;
  endtask

  task automatic wait_acc(input int n, input int lim);
    int k = 0;
    while (acc_cnt < n && k < lim) begin @(negedge clk_i); #1; k++; end
    if (acc_cnt < n) chk("timeout_fetch", acc_cnt, n);
  endtask

  task automatic wait_term(input int lim);
    int k = 0;
    while (!(halted_o || error_o) && k < lim) begin @(negedge clk_i); #1; k++; end
    if (!(halted_o || error_o)) chk("timeout_terminal", {halted_o, error_o}, 2'b11);
    repeat (2) @(negedge clk_i);
    #1;
  endtask

  task automatic fill(input logic [7:0] v);
    for (int i = 0; i < 256; i++) mem[i] = v;
  endtask

  function automatic logic [7:0] rand_op_byte();
    logic [2:0] cls;
    cls = ($urandom_range(0, 99) < 96) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(5, 7));
    return {cls, 5'($urandom)};
  endfunction

  initial begin
    int k;
    // reset mid-fetch
    for (int i = 0; i < 256; i++) mem[i] = i[0] ? 8'h7F : 8'h25;
    wait_mode = 0;
    do_reset();
    wait_acc(3, 60);
    wait_mode = 6;
    k = 0;
    while (!(mem_req_o && was_waiting) && k < 40) begin @(negedge clk_i); #1; k++; end
    chk("midfetch_reached", mem_req_o && was_waiting, 1'b1);
    chk("pre_reset_a", a_o, 8'h7F);
    #2 rst_i = 1'b1;
    force_valid = 1'b1;
    #1;
    chk("rst_req", mem_req_o, 1'b0);
    chk("rst_pc", pc_o, 8'h00);
    chk("rst_addr", mem_addr_o, 8'h00);
    chk("rst_a", a_o, 8'h00);
    chk("rst_flags", flags_o, 4'h0);
    chk("rst_alu", {alu_a_o, alu_b_o, alu_op_o}, 21'h0);
    chk("rst_status", {halted_o, error_o}, 2'b00);
    wait_mode = 0;
    repeat (2) @(negedge clk_i);
    @(posedge clk_i); #1 rst_i = 1'b0;
    force_valid = 1'b0;
    @(negedge clk_i); #1;
    chk("release_idle_req", mem_req_o, 1'b0);
    @(negedge clk_i); #1;
    chk("release_req", mem_req_o, 1'b1);
    chk("release_addr", mem_addr_o, 8'h00);

    // arithmetic, zero-wait: PASS_B 0x7F then ADD 0x01
    fill(8'hA0);
    mem[0] = 8'h25; mem[1] = 8'h7F; mem[2] = 8'h20; mem[3] = 8'h01;
    wait_mode = 0;
    do_reset();
    wait_term(100);
    chk("arith_a", a_o, 8'h80);
    chk("arith_flags", flags_o, 4'b1100);
    chk("arith_gap", q_gap(0), 4);
    chk("arith_halt", halted_o, 1'b1);

    // same program with 3 wait cycles on every fetch
    wait_mode = 3;
    do_reset();
    wait_term(200);
    chk("wait_a", a_o, 8'h80);
    chk("wait_gap", q_gap(0), 10);

    // branch on Z set, taken
    fill(8'hA0);
    mem[0] = 8'h25; mem[1] = 8'hFF; mem[2] = 8'h20; mem[3] = 8'h01; mem[4] = 8'h84; mem[5] = 8'h40;
    wait_mode = 0;
    do_reset();
    wait_term(100);
    chk("br_a", a_o, 8'h00);
    chk("br_flags", flags_o, 4'b0011);
    chk("br_taken_addr", q_addr(3), 8'h40);
    chk("br_taken_pc", pc_o, 8'h41);
    // Z clear condition, not taken
    mem[4] = 8'h80;
    do_reset();
    wait_term(100);
    chk("br_not_taken_addr", q_addr(3), 8'h06);

    // JMP 0xFF onto LDB, immediate wraps to 0x00
    fill(8'hA0);
    mem[0] = 8'h25; mem[1] = 8'h80; mem[2] = 8'h60; mem[3] = 8'hFF; mem[8'hFF] = 8'h40;
    wait_mode = -1;
    do_reset();
    wait_term(200);
    chk("wrap_ldb_addr", q_addr(2), 8'hFF);
    chk("wrap_next_addr", q_addr(3), 8'h01);
    chk("wrap_b", alu_b_o, 8'h25);
    chk("wrap_flags", flags_o, 4'b1000);
    chk("wrap_pc", pc_o, 8'h61);

    // terminal states
    fill(8'hC0);
    wait_mode = 0;
    do_reset();
    wait_term(50);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i); #1;
      chk("err_sticky", {error_o, halted_o, mem_req_o}, 3'b100);
    end
    do_reset();
    #1 chk("err_cleared", error_o, 1'b0);
    fill(8'hA0);
    do_reset();
    wait_term(50);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i); #1;
      chk("halt_sticky", {halted_o, error_o, mem_req_o}, 3'b100);
    end
    do_reset();
    #1 chk("halt_cleared", halted_o, 1'b0);

    // randomized programs with random wait states
    for (int p = 0; p < 10; p++) begin
      for (int i = 0; i < 256; i++) mem[i] = rand_op_byte();
      wait_mode = -1;
      do_reset();
      k = 0;
      while (k < 1500 && acc_cnt < 150 && !(m_term != 0 && cyc > term_cyc + 3)) begin
        @(negedge clk_i); #1; k++;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
